// File: rtl/z80_mem_arbiter_pkg.sv
// Shared types for the Z80 memory arbiter: access owner encoding and counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package z80_arb_pkg;

    // Owner of an issued access; recorded alongside the in-flight flag so
    // the return cycle knows whom the memory data belongs to.
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } arb_owner_t;

    // Width of the DMA starvation counter; holds DMA_STARVE_MAX up to 15.
    localparam int STARVE_W = 4;

endpackage : z80_arb_pkg

// File: rtl/z80_mem_arbiter_if.sv
// Bus bundle between the arbiter, the Z80 CPU, the secondary fetch master and the memory.
// Latency: n/a (wires only).
// Backpressure: CPU stalled via cpu_mwait; DMA holds dma_req/dma_addr until dma_gnt.
//
// Signals:
//   cpu_req/cpu_addr    CPU read request (level) and address
//   cpu_rdata/cpu_mwait registered CPU read data, wait line (0 = wait)
//   dma_req/dma_addr    secondary master request (level) and address
//   dma_gnt/dma_valid   address-taken pulse, data-valid pulse one cycle later
//   dma_rdata           pass-through of memory data for the secondary master
//   mem_ena/mem_addr    memory read strobe and address
//   mem_rdata           memory output register
// Modports: slave = arbiter view, master = environment (CPU, DMA, memory) view.
interface z80_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_mwait;

    logic              dma_req;
    logic [ADDR_W-1:0] dma_addr;
    logic              dma_gnt;
    logic              dma_valid;
    logic [DATA_W-1:0] dma_rdata;

    logic              mem_ena;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_addr,
        output cpu_rdata, cpu_mwait,
        input  dma_req, dma_addr,
        output dma_gnt, dma_valid, dma_rdata,
        output mem_ena, mem_addr,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_addr,
        input  cpu_rdata, cpu_mwait,
        output dma_req, dma_addr,
        input  dma_gnt, dma_valid, dma_rdata,
        input  mem_ena, mem_addr,
        output mem_rdata
    );

endinterface : z80_mem_arbiter_if

// File: rtl/z80_mem_arbiter_starve_sel.sv
// Two-way priority select (CPU first) with a DMA starvation counter that forces a DMA win.
// Latency: combinational select; counter updates on the clock edge.
// Backpressure: none; the loser simply retries next cycle.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   cpu_elig     CPU has a request that may issue this cycle
//   dma_req      secondary master is requesting
//   win_vld      some master issues this cycle
//   win_own      which master issues (meaningful when win_vld=1)
module arb_starve_sel
    import z80_arb_pkg::*;
#(
    parameter int DMA_STARVE_MAX = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_elig,
    input  logic       dma_req,
    output logic       win_vld,
    output arb_owner_t win_own
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(DMA_STARVE_MAX);

    logic [STARVE_W-1:0] starve_cnt;
    logic                dma_force;

    assign dma_force = (starve_cnt == STARVE_LIM);

    always_comb begin
        win_vld = cpu_elig | dma_req;
        win_own = OWN_CPU;
        // DMA takes the slot when it is alone or has lost too many times in a row.
        if (dma_req && (!cpu_elig || dma_force)) begin
            win_own = OWN_DMA;
        end
    end

    // Counts consecutive DMA losses. Any cycle without a DMA request, or with a
    // DMA grant, restarts the count. Reaching the else-branch means dma_req=1
    // and the CPU took the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!dma_req || win_own == OWN_DMA) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule : arb_starve_sel

// File: rtl/z80_mem_arbiter.sv
// Shares one 1-cycle synchronous-read memory between the Z80 CPU and a secondary fetch master.
// Latency: issue cycle + 1 return cycle; one access per cycle with one in flight.
// Backpressure: CPU stalled with cpu_mwait=0 until its data is registered; DMA waits for dma_gnt.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          z80_mem_arbiter_if.slave: CPU, DMA and memory sides
module z80_mem_arbiter
    import z80_arb_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 8,
    parameter int DMA_STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    z80_mem_arbiter_if.slave    bus
);

    logic       inflight_vld;
    arb_owner_t inflight_own;
    logic       cpu_done;
    logic       cpu_ret;
    logic       cpu_elig;
    logic       win_vld;
    arb_owner_t win_own;
    logic       issue;

    // CPU data returns in the cycle after its issue.
    assign cpu_ret = inflight_vld && (inflight_own == OWN_CPU);

    // The CPU holds cpu_req through the stall, so it must be masked while its
    // access is in flight and after completion until cpu_req drops.
    assign cpu_elig = bus.cpu_req & ~cpu_done & ~cpu_ret;

    arb_starve_sel #(
        .DMA_STARVE_MAX (DMA_STARVE_MAX)
    ) u_sel (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_elig (cpu_elig),
        .dma_req  (bus.dma_req),
        .win_vld  (win_vld),
        .win_own  (win_own)
    );

    // Outputs are gated by rst_n so that nothing issues while reset is held,
    // even though the request inputs feed the select combinationally.
    assign issue         = rst_n & win_vld;
    assign bus.mem_ena   = issue;
    assign bus.mem_addr  = (win_own == OWN_DMA) ? bus.dma_addr : bus.cpu_addr;
    assign bus.dma_gnt   = issue & (win_own == OWN_DMA);
    assign bus.dma_valid = inflight_vld & (inflight_own == OWN_DMA);
    assign bus.dma_rdata = bus.mem_rdata;
    assign bus.cpu_mwait = ~(rst_n & bus.cpu_req & ~cpu_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_vld  <= 1'b0;
            inflight_own  <= OWN_CPU;
            cpu_done      <= 1'b0;
            bus.cpu_rdata <= '0;
        end else begin
            inflight_vld <= issue;
            inflight_own <= win_own;
            if (cpu_ret) begin
                bus.cpu_rdata <= bus.mem_rdata;
            end
            // A completed request stays done until the CPU releases cpu_req.
            if (!bus.cpu_req) begin
                cpu_done <= 1'b0;
            end else if (cpu_ret) begin
                cpu_done <= 1'b1;
            end
        end
    end

endmodule : z80_mem_arbiter

// File: tb/tb_z80_mem_arbiter.sv
// Self-checking bench for z80_mem_arbiter: directed stimulus, data scoreboard, cycle-level checks.
module tb_z80_mem_arbiter;
    import z80_arb_pkg::*;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 8;
    localparam int STARVE_MAX = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    z80_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    z80_mem_arbiter #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .DMA_STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] cpu_q[$];
    logic [7:0] dma_q[$];
    logic [7:0] dma_tab [0:4];
    bit         cpu_seen;

    // Memory contents (hand-chosen values at the addresses the tests use).
    function automatic logic [7:0] mem_val(input logic [15:0] a);
        case (a)
            16'h0010: mem_val = 8'hA5;
            16'h0100: mem_val = 8'h11;
            16'h0101: mem_val = 8'h22;
            16'h0102: mem_val = 8'h33;
            16'h0103: mem_val = 8'h44;
            16'h0104: mem_val = 8'h55;
            16'h0200: mem_val = 8'h5C;
            16'h0300: mem_val = 8'hC3;
            default:  mem_val = 8'hEE;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.mem_ena) bus.mem_rdata <= mem_val(bus.mem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops expected data whenever the DUT presents a result.
    always @(negedge clk) begin
        if (!rst_n) begin
            cpu_seen = 1'b0;
        end else begin
            if (bus.dma_valid) begin
                if (dma_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dma_unexpected_valid actual=0x%0h required=no_pulse t=%0t",
                             bus.dma_rdata, $time);
                end else begin
                    check("dma_rdata", 32'(bus.dma_rdata), 32'(dma_q.pop_front()));
                end
            end
            if (bus.cpu_req && !bus.cpu_mwait) begin
                cpu_seen = 1'b1;
            end else if (bus.cpu_req && bus.cpu_mwait && cpu_seen) begin
                cpu_seen = 1'b0;
                if (cpu_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL cpu_unexpected_done actual=0x%0h required=no_completion t=%0t",
                             bus.cpu_rdata, $time);
                end else begin
                    check("cpu_rdata", 32'(bus.cpu_rdata), 32'(cpu_q.pop_front()));
                end
            end
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for the CPU access to complete, then releases cpu_req.
    task automatic finish_cpu(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            if (bus.cpu_mwait) done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=mwait_low required=mwait_high t=%0t", name, $time);
        end
        drive_edge();
        bus.cpu_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit         obs_gnt;
        bit         obs_mwait;
        int         m;
        int         di;

        dma_tab[0] = 8'h11; dma_tab[1] = 8'h22; dma_tab[2] = 8'h33;
        dma_tab[3] = 8'h44; dma_tab[4] = 8'h55;
        bus.cpu_req  = 1'b0;
        bus.cpu_addr = '0;
        bus.dma_req  = 1'b0;
        bus.dma_addr = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_mem_ena",   32'(bus.mem_ena), 32'd0);
        check("rst_cpu_mwait", 32'(bus.cpu_mwait), 32'd1);
        check("rst_dma_gnt",   32'(bus.dma_gnt), 32'd0);
        check("rst_dma_valid", 32'(bus.dma_valid), 32'd0);
        check("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);

        // CPU only, then held request and re-request
        drive_edge();
        bus.cpu_addr = 16'h0010;
        bus.cpu_req  = 1'b1;
        cpu_q.push_back(8'hA5);
        @(negedge clk);
        check("cpu_c0_mem_ena",  32'(bus.mem_ena), 32'd1);
        check("cpu_c0_mem_addr", 32'(bus.mem_addr), 32'h0010);
        check("cpu_c0_mwait",    32'(bus.cpu_mwait), 32'd0);
        @(negedge clk);
        check("cpu_c1_mwait",    32'(bus.cpu_mwait), 32'd0);
        check("cpu_c1_mem_ena",  32'(bus.mem_ena), 32'd0);
        @(negedge clk);
        check("cpu_c2_mwait",    32'(bus.cpu_mwait), 32'd1);
        check("cpu_c2_rdata",    32'(bus.cpu_rdata), 32'hA5);
        check("cpu_c2_mem_ena",  32'(bus.mem_ena), 32'd0);
        @(negedge clk);
        check("cpu_hold_mem_ena", 32'(bus.mem_ena), 32'd0);
        check("cpu_hold_mwait",   32'(bus.cpu_mwait), 32'd1);
        drive_edge();
        bus.cpu_req = 1'b0;
        @(negedge clk);
        check("cpu_drop_mem_ena", 32'(bus.mem_ena), 32'd0);
        drive_edge();
        bus.cpu_addr = 16'h0200;
        bus.cpu_req  = 1'b1;
        cpu_q.push_back(8'h5C);
        @(negedge clk);
        check("cpu_rereq_mem_ena",  32'(bus.mem_ena), 32'd1);
        check("cpu_rereq_mem_addr", 32'(bus.mem_addr), 32'h0200);
        finish_cpu("cpu_rereq");

        // DMA stream of four back-to-back accesses
        for (int k = 0; k < 6; k++) begin
            drive_edge();
            bus.dma_req  = (k < 4);
            bus.dma_addr = 16'h0100 + 16'(k);
            if (k < 4) dma_q.push_back(dma_tab[k]);
            @(negedge clk);
            check("dma_stream_gnt",   32'(bus.dma_gnt), 32'(k < 4));
            check("dma_stream_valid", 32'(bus.dma_valid), 32'(k >= 1 && k <= 4));
            if (k < 4) check("dma_stream_addr", 32'(bus.mem_addr), 32'h0100 + 32'(k));
        end

        // Contention: CPU first, DMA next cycle
        drive_edge();
        bus.cpu_addr = 16'h0300;
        bus.cpu_req  = 1'b1;
        bus.dma_addr = 16'h0104;
        bus.dma_req  = 1'b1;
        cpu_q.push_back(8'hC3);
        dma_q.push_back(8'h55);
        @(negedge clk);
        check("cont_c0_mem_ena",  32'(bus.mem_ena), 32'd1);
        check("cont_c0_mem_addr", 32'(bus.mem_addr), 32'h0300);
        check("cont_c0_gnt",      32'(bus.dma_gnt), 32'd0);
        check("cont_c0_starve",   32'(dut.u_sel.starve_cnt), 32'd0);
        @(negedge clk);
        check("cont_c1_gnt",      32'(bus.dma_gnt), 32'd1);
        check("cont_c1_mem_addr", 32'(bus.mem_addr), 32'h0104);
        check("cont_c1_mwait",    32'(bus.cpu_mwait), 32'd0);
        check("cont_c1_starve",   32'(dut.u_sel.starve_cnt), 32'd1);
        drive_edge();
        bus.dma_req = 1'b0;
        @(negedge clk);
        check("cont_c2_valid",  32'(bus.dma_valid), 32'd1);
        check("cont_c2_mwait",  32'(bus.cpu_mwait), 32'd1);
        check("cont_c2_rdata",  32'(bus.cpu_rdata), 32'hC3);
        check("cont_c2_starve", 32'(dut.u_sel.starve_cnt), 32'd0);
        drive_edge();
        bus.cpu_req = 1'b0;
        @(negedge clk);

        // Starvation: DMA held, CPU re-requests whenever it can
        m = 0;
        di = 0;
        obs_gnt = 1'b0;
        obs_mwait = 1'b0;
        bus.dma_addr = 16'h0100;
        for (int c = 0; c < 16; c++) begin
            drive_edge();
            bus.dma_req = 1'b1;
            if (obs_gnt) begin
                di++;
                bus.dma_addr = 16'h0100 + 16'(di % 4);
            end
            if (!bus.cpu_req) begin
                bus.cpu_req  = 1'b1;
                bus.cpu_addr = 16'h0010;
                cpu_q.push_back(8'hA5);
            end else if (obs_mwait) begin
                bus.cpu_req = 1'b0;
            end
            @(negedge clk);
            check("starve_cnt", 32'(dut.u_sel.starve_cnt), 32'(m));
            if (m == STARVE_MAX) check("starve_forced_gnt", 32'(bus.dma_gnt), 32'd1);
            if (bus.dma_gnt) begin
                dma_q.push_back(dma_tab[di % 4]);
                m = 0;
            end else if (bus.mem_ena) begin
                m = (m < STARVE_MAX) ? m + 1 : m;
            end
            obs_gnt   = bus.dma_gnt;
            obs_mwait = bus.cpu_mwait;
        end
        drive_edge();
        bus.dma_req = 1'b0;
        if (bus.cpu_req && obs_mwait) bus.cpu_req = 1'b0;
        @(negedge clk);
        if (bus.cpu_req) finish_cpu("starve_drain");
        repeat (3) @(negedge clk);
        check("starve_end_cnt", 32'(dut.u_sel.starve_cnt), 32'd0);
        check("cpu_q_empty", 32'(cpu_q.size()), 32'd0);
        check("dma_q_empty", 32'(dma_q.size()), 32'd0);

        // Reset in the DMA return cycle
        drive_edge();
        bus.dma_addr = 16'h0101;
        bus.dma_req  = 1'b1;
        @(negedge clk);
        check("rst_mid_gnt", 32'(bus.dma_gnt), 32'd1);
        drive_edge();
        bus.dma_req = 1'b0;
        #1 rst_n = 1'b0;
        bus.cpu_addr = 16'h0010;
        bus.cpu_req  = 1'b1;
        #1;
        check("rst_mid_valid",   32'(bus.dma_valid), 32'd0);
        check("rst_mid_mem_ena", 32'(bus.mem_ena), 32'd0);
        check("rst_mid_mwait",   32'(bus.cpu_mwait), 32'd1);
        check("rst_mid_rdata",   32'(bus.cpu_rdata), 32'd0);
        drive_edge();
        check("rst_hold_mem_ena", 32'(bus.mem_ena), 32'd0);
        check("rst_hold_valid",   32'(bus.dma_valid), 32'd0);
        #1 rst_n = 1'b1;
        cpu_q.push_back(8'hA5);
        @(negedge clk);
        check("rst_rel_mem_ena", 32'(bus.mem_ena), 32'd1);
        check("rst_rel_mwait",   32'(bus.cpu_mwait), 32'd0);
        finish_cpu("rst_rel_cpu");
        repeat (2) @(negedge clk);
        check("final_cpu_q_empty", 32'(cpu_q.size()), 32'd0);
        check("final_dma_q_empty", 32'(dma_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_z80_mem_arbiter
